// File: rtl/sauria_eoc_pkg.sv
// Shared types and helpers for the SAURIA end-of-computation collector.
// Exit words use the Cheshire scratch layout: bit0 = EOC flag, upper bits = exit code.
package sauria_eoc_pkg;

   typedef enum logic {
      WAIT_ALL = 1'b0,
      WAIT_ANY = 1'b1
   } mode_e;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      DONE    = 2'd2,
      TIMEOUT = 2'd3
   } state_e;

   localparam int EocFlagBit   = 0;
   localparam int MaxCodeWidth = 63;

   typedef logic [MaxCodeWidth:0]   eoc_word_t;
   typedef logic [MaxCodeWidth-1:0] eoc_code_t;

   // Callers zero-extend the channel word and truncate the result to their code width.
   function automatic eoc_code_t eoc_code(input eoc_word_t word);
      return word[MaxCodeWidth:1];
   endfunction

endpackage

// File: rtl/sauria_eoc_collector.sv
// Multi-channel end-of-computation collector: aggregates per-agent exit words into one
// SoC exit status and aborts with a timeout if progress stalls.
module sauria_eoc_collector
   import sauria_eoc_pkg::*;
#(
   parameter int NumCh           = 4,
   parameter int CodeWidth       = 31,
   parameter int CntWidth        = 32,
   parameter bit KickOnHeartbeat = 1'b1,
   localparam int ChW            = (NumCh > 1) ? $clog2(NumCh) : 1,
   localparam int WordW          = CodeWidth + 1
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   start_i,
   input  logic                   clear_i,
   input  logic                   mode_i,
   input  logic [NumCh-1:0]       ch_en_i,
   input  logic [CntWidth-1:0]    timeout_i,
   input  logic [NumCh-1:0]       eoc_valid_i,
   input  logic [NumCh*WordW-1:0] eoc_word_i,
   output logic [NumCh-1:0]       eoc_ready_o,
   output logic                   busy_o,
   output logic                   done_o,
   output logic                   timeout_o,
   output logic                   pass_o,
   output logic [CodeWidth-1:0]   exit_code_o,
   output logic [ChW-1:0]         exit_ch_o,
   output logic [NumCh-1:0]       seen_o,
   output logic                   dup_o
);

   state_e               state_r, state_next_s;
   mode_e                mode_r;
   logic [NumCh-1:0]     ch_en_r, seen_r;
   logic [CntWidth-1:0]  timeout_r, cnt_r, cnt_next_s;
   logic                 dup_r, done_r, timeout_flag_r, pass_r;
   logic [CodeWidth-1:0] code_r, code_next_s;
   logic [ChW-1:0]       exit_ch_r, exit_ch_next_s;

   logic [CodeWidth-1:0] code_s [NumCh];
   logic [NumCh-1:0]     flag_s, nz_s, xfer_s, eoc_s, seen_next_s, pick_vec_s;
   logic [ChW-1:0]       pick_idx_s;
   logic                 pick_any_s, upd_s;
   logic                 arm_s, active_s, kick_s, complete_s, expire_s;

   assign eoc_ready_o = {NumCh{state_r == ARMED}} & ch_en_r;
   assign xfer_s      = eoc_valid_i & eoc_ready_o;
   assign eoc_s       = xfer_s & flag_s;
   assign seen_next_s = seen_r | eoc_s;
   assign kick_s      = KickOnHeartbeat & (|(xfer_s & ~flag_s));
   assign arm_s       = start_i & (state_r != ARMED);
   assign active_s    = (state_r == ARMED) & ~clear_i;

   // Split every channel word into its EOC flag and exit code.
   always_comb begin
      for (int i = 0; i < NumCh; i++) begin
         flag_s[i] = eoc_word_i[i*WordW + EocFlagBit];
         code_s[i] = CodeWidth'(eoc_code(eoc_word_t'(eoc_word_i[i*WordW +: WordW])));
         nz_s[i]   = eoc_s[i] & ~seen_r[i] & (code_s[i] != '0);
      end
   end

   // An empty enable mask completes immediately so the boot flow never waits on nothing.
   assign complete_s = (ch_en_r == '0) |
                       ((mode_r == WAIT_ANY) ? (|eoc_s) : (seen_next_s == ch_en_r));
   assign expire_s   = (timeout_r != '0) & (cnt_r == (timeout_r - CntWidth'(1))) & ~complete_s;

   // Lowest-index priority pick over the candidate code sources.
   always_comb begin
      pick_vec_s = (mode_r == WAIT_ANY) ? eoc_s : nz_s;
      pick_any_s = |pick_vec_s;
      pick_idx_s = '0;
      for (int i = NumCh - 1; i >= 0; i--) begin
         pick_idx_s = pick_vec_s[i] ? ChW'(i) : pick_idx_s;
      end
   end

   // Code selection: WAIT_ANY takes the first EOC, WAIT_ALL keeps the first nonzero code.
   always_comb begin
      upd_s = pick_any_s & ((mode_r == WAIT_ANY) | (code_r == '0));
      if (upd_s) begin
         code_next_s    = code_s[pick_idx_s];
         exit_ch_next_s = pick_idx_s;
      end else begin
         code_next_s    = code_r;
         exit_ch_next_s = exit_ch_r;
      end
   end

   // Saturating progress counter, restarted by heartbeat words.
   always_comb begin
      if (kick_s) begin
         cnt_next_s = '0;
      end else if ((timeout_r != '0) && (cnt_r != {CntWidth{1'b1}})) begin
         cnt_next_s = cnt_r + CntWidth'(1);
      end else begin
         cnt_next_s = cnt_r;
      end
   end

   // Next-state logic; start beats clear, and start is ignored while armed.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE: begin
            if (start_i) state_next_s = ARMED;
            else         state_next_s = IDLE;
         end
         ARMED: begin
            if (clear_i)         state_next_s = IDLE;
            else if (complete_s) state_next_s = DONE;
            else if (expire_s)   state_next_s = TIMEOUT;
            else                 state_next_s = ARMED;
         end
         DONE, TIMEOUT: begin
            if (start_i)      state_next_s = ARMED;
            else if (clear_i) state_next_s = IDLE;
            else              state_next_s = state_r;
         end
         default: state_next_s = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_r <= IDLE;
      else         state_r <= state_next_s;
   end

   // Latched configuration and aggregated status.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mode_r         <= WAIT_ALL;
         ch_en_r        <= '0;
         timeout_r      <= '0;
         cnt_r          <= '0;
         seen_r         <= '0;
         dup_r          <= 1'b0;
         done_r         <= 1'b0;
         timeout_flag_r <= 1'b0;
         pass_r         <= 1'b0;
         code_r         <= '0;
         exit_ch_r      <= '0;
      end else if (arm_s) begin
         mode_r         <= mode_e'(mode_i);
         ch_en_r        <= ch_en_i;
         timeout_r      <= timeout_i;
         cnt_r          <= '0;
         seen_r         <= '0;
         dup_r          <= 1'b0;
         done_r         <= 1'b0;
         timeout_flag_r <= 1'b0;
         pass_r         <= 1'b0;
         code_r         <= '0;
         exit_ch_r      <= '0;
      end else if (active_s) begin
         cnt_r          <= cnt_next_s;
         seen_r         <= seen_next_s;
         dup_r          <= dup_r | (|(eoc_s & seen_r));
         code_r         <= code_next_s;
         exit_ch_r      <= exit_ch_next_s;
         done_r         <= complete_s | expire_s;
         timeout_flag_r <= expire_s;
         pass_r         <= complete_s & (code_next_s == '0);
      end else begin
         done_r         <= 1'b0;
      end
   end

   assign busy_o      = (state_r == ARMED);
   assign done_o      = done_r;
   assign timeout_o   = timeout_flag_r;
   assign pass_o      = pass_r;
   assign exit_code_o = code_r;
   assign exit_ch_o   = exit_ch_r;
   assign seen_o      = seen_r;
   assign dup_o       = dup_r;

endmodule

// File: tb/tb_sauria_eoc_collector.sv
// Scoreboarded random + directed bench for sauria_eoc_collector against a cycle-list model.
module tb_sauria_eoc_collector;

   localparam int MAXJ = 80;

   logic         clk = 1'b0;
   logic         rst_ni = 1'b0;
   logic         start_i = 1'b0;
   logic         clear_i = 1'b0;
   logic         mode_i = 1'b0;
   logic [3:0]   ch_en_i = 4'h0;
   logic [31:0]  timeout_i = 32'd0;
   logic [3:0]   eoc_valid_i = 4'h0;
   logic [127:0] eoc_word_i = 128'd0;
   logic [3:0]   eoc_ready_o;
   logic         busy_o, done_o, timeout_o, pass_o, dup_o;
   logic [30:0]  exit_code_o;
   logic [1:0]   exit_ch_o;
   logic [3:0]   seen_o;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   typedef struct {
      int          cyc;
      bit          to;
      bit          pass;
      bit          dup;
      logic [30:0] code;
      logic [1:0]  ch;
      logic [3:0]  seen;
   } exp_t;

   exp_t expq[$];
   exp_t me;

   logic [3:0]  sv [MAXJ];
   logic [31:0] sw [MAXJ][4];

   sauria_eoc_collector dut (
      .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .clear_i(clear_i),
      .mode_i(mode_i), .ch_en_i(ch_en_i), .timeout_i(timeout_i),
      .eoc_valid_i(eoc_valid_i), .eoc_word_i(eoc_word_i), .eoc_ready_o(eoc_ready_o),
      .busy_o(busy_o), .done_o(done_o), .timeout_o(timeout_o), .pass_o(pass_o),
      .exit_code_o(exit_code_o), .exit_ch_o(exit_ch_o), .seen_o(seen_o), .dup_o(dup_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   task automatic clr_sched();
      for (int j = 0; j < MAXJ; j++) begin
         sv[j] = 4'h0;
         for (int k = 0; k < 4; k++) sw[j][k] = 32'd0;
      end
   endtask

   task automatic put(input int j, input int k, input logic [31:0] w);
      sv[j][k] = 1'b1;
      sw[j][k] = w;
   endtask

   // Reference: walk the armed cycles of the schedule and apply the collector rules.
   function automatic void model(input bit any, input logic [3:0] en, input int t,
                                 output bit term, output int jend, output exp_t e);
      logic [3:0]  seen, eocs;
      logic [30:0] code;
      logic [1:0]  ch;
      bit          dup, hb, fin, to;
      int          c, pick;
      seen = 4'h0; code = 31'd0; ch = 2'd0; dup = 1'b0; c = 0;
      term = 1'b0; jend = 0;
      e = '{cyc: 0, to: 1'b0, pass: 1'b0, dup: 1'b0, code: 31'd0, ch: 2'd0, seen: 4'h0};
      for (int j = 0; j < MAXJ; j++) begin
         eocs = 4'h0; hb = 1'b0;
         for (int k = 0; k < 4; k++) begin
            if (sv[j][k] && en[k]) begin
               if (sw[j][k][0]) eocs[k] = 1'b1;
               else             hb = 1'b1;
            end
         end
         pick = -1;
         for (int k = 3; k >= 0; k--) begin
            if (eocs[k] && (any || (!seen[k] && sw[j][k][31:1] != 31'd0))) pick = k;
         end
         if (pick >= 0 && (any || code == 31'd0)) begin
            code = sw[j][pick][31:1];
            ch   = pick[1:0];
         end
         if ((eocs & seen) != 4'h0) dup = 1'b1;
         seen = seen | eocs;
         fin = any ? (eocs != 4'h0 || en == 4'h0) : (seen == en);
         to  = !fin && t != 0 && c == t - 1;
         if (fin || to) begin
            term = 1'b1; jend = j;
            e.to = to; e.pass = fin && code == 31'd0; e.dup = dup;
            e.code = code; e.ch = ch; e.seen = seen;
            return;
         end
         if (hb) c = 0;
         else if (t != 0) c = c + 1;
      end
   endfunction

   task automatic run_episode(input bit any, input logic [3:0] en, input int t,
                              input int len, input bit with_clear);
      bit   term;
      int   jend, a, last;
      exp_t e;
      model(any, en, t, term, jend, e);
      start_i = 1'b1; clear_i = with_clear; mode_i = any; ch_en_i = en; timeout_i = t;
      @(negedge clk);
      a = cyc; start_i = 1'b0; clear_i = 1'b0;
      chk("armed_busy", busy_o, 1);
      if (term) begin
         e.cyc = a + 1 + jend;
         expq.push_back(e);
      end
      last = term ? jend : len - 1;
      for (int j = 0; j <= last; j++) begin
         eoc_valid_i = sv[j];
         eoc_word_i  = {sw[j][3], sw[j][2], sw[j][1], sw[j][0]};
         chk("ready", eoc_ready_o, en);
         @(negedge clk);
      end
      eoc_valid_i = 4'h0; eoc_word_i = 128'd0;
      if (term) begin
         for (int w = 0; w < 10 && expq.size() != 0; w++) @(negedge clk);
         if (expq.size() != 0) begin
            chk("done_missing", expq.size(), 0);
            expq.delete();
         end
      end else begin
         clear_i = 1'b1;
         @(negedge clk);
         clear_i = 1'b0;
         chk("abort_busy", busy_o, 0);
         chk("abort_ready", eoc_ready_o, 0);
      end
   endtask

   // Monitor: every done pulse must match the oldest expected completion.
   always @(negedge clk) begin
      if (rst_ni && done_o) begin
         if (expq.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_done: done_o=1 at cycle %0d, required 0", cyc);
         end else begin
            me = expq.pop_front();
            chk("done_cycle", cyc, me.cyc);
            chk("timeout_o", timeout_o, me.to);
            chk("pass_o", pass_o, me.pass);
            chk("dup_o", dup_o, me.dup);
            chk("exit_code_o", exit_code_o, me.code);
            chk("exit_ch_o", exit_ch_o, me.ch);
            chk("seen_o", seen_o, me.seen);
            chk("done_busy", busy_o, 0);
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          len, choice;
      logic [30:0] w;
      bit          fl, wc;
      logic [3:0]  en;
      int          t;

      repeat (3) @(negedge clk);
      chk("rst_busy", busy_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_code", exit_code_o, 0);
      chk("rst_seen", seen_o, 0);
      chk("rst_ready", eoc_ready_o, 0);
      rst_ni = 1'b1;
      @(negedge clk);

      clr_sched(); put(0, 2, 32'h1); put(1, 0, 32'h1); put(2, 3, 32'h1); put(3, 1, 32'h1);
      run_episode(1'b0, 4'hF, 1000, 4, 1'b0);
      clr_sched(); put(0, 1, 32'hB); put(2, 3, 32'hF); put(3, 0, 32'h1); put(4, 2, 32'h1);
      run_episode(1'b0, 4'hF, 1000, 5, 1'b0);
      clr_sched(); put(0, 2, 32'h7); put(0, 0, 32'h3);
      run_episode(1'b1, 4'hF, 1000, 1, 1'b0);
      clr_sched();
      run_episode(1'b0, 4'hF, 10, 12, 1'b0);
      clr_sched(); put(8, 0, 32'h0);
      run_episode(1'b0, 4'hF, 10, 12, 1'b1);
      clr_sched(); put(0, 0, 32'h3); put(2, 0, 32'h5); put(4, 1, 32'h1);
      run_episode(1'b0, 4'h3, 1000, 5, 1'b0);

      // Asynchronous reset while armed with two channels seen.
      start_i = 1'b1; mode_i = 1'b0; ch_en_i = 4'hF; timeout_i = 32'd0;
      @(negedge clk);
      start_i = 1'b0;
      eoc_valid_i = 4'b0011; eoc_word_i = {32'h0, 32'h0, 32'h5, 32'h3};
      @(negedge clk);
      eoc_valid_i = 4'h0; eoc_word_i = 128'd0;
      chk("pre_rst_seen", seen_o, 4'b0011);
      #2 rst_ni = 1'b0;
      #1;
      chk("midrst_busy", busy_o, 0);
      chk("midrst_seen", seen_o, 0);
      chk("midrst_code", exit_code_o, 0);
      chk("midrst_ch", exit_ch_o, 0);
      chk("midrst_ready", eoc_ready_o, 0);
      chk("midrst_flags", {done_o, timeout_o, pass_o, dup_o}, 0);
      @(negedge clk);
      rst_ni = 1'b1;
      @(negedge clk);
      clr_sched();
      run_episode(1'b0, 4'h0, 0, 1, 1'b0);

      wc = 1'b0;
      for (int ep = 0; ep < 45; ep++) begin
         clr_sched();
         len = $urandom_range(5, 30);
         for (int j = 0; j < len; j++) begin
            for (int k = 0; k < 4; k++) begin
               if ($urandom_range(0, 2) == 0) begin
                  w  = ($urandom_range(0, 1) == 0) ? 31'd0 : 31'($urandom_range(1, 20));
                  fl = ($urandom_range(0, 3) == 0);
                  put(j, k, {w, fl});
               end
            end
         end
         en = 4'($urandom_range(0, 15));
         t  = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(3, 40);
         run_episode(1'($urandom_range(0, 1)), en, t, len, wc);
         choice = $urandom_range(0, 2);
         wc = (choice == 2);
         if (choice == 1) begin
            clear_i = 1'b1;
            @(negedge clk);
            clear_i = 1'b0;
            chk("clear_busy", busy_o, 0);
            chk("clear_ready", eoc_ready_o, 0);
         end
      end

      repeat (3) @(negedge clk);
      chk("queue_empty", expq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
